// File: rtl/spi_master_if.sv
// Host-side handshake and SPI pins of the spi_master, grouped as one bundle.
// The master modport is the DUT's view; slave is the host/bench view.
interface spi_master_if #(
    parameter int unsigned FRAME_W = 10,
    parameter int unsigned RD_W    = 8
);
    logic               start;
    logic [FRAME_W-1:0] tx_frame;
    logic               busy;
    logic               done;
    logic [RD_W-1:0]    rx_data;
    logic               rx_valid;
    logic               MOSI;
    logic               MISO;
    logic               SS_n;

    modport master (
        input  start, tx_frame, MISO,
        output busy, done, rx_data, rx_valid, MOSI, SS_n
    );

    modport slave (
        output start, tx_frame, MISO,
        input  busy, done, rx_data, rx_valid, MOSI, SS_n
    );
endinterface

// File: rtl/spi_master.sv
// SPI master for the 10-bit command/data protocol: serializes a frame MSB-first
// under SS_n and, for read-data commands, captures an RD_W-bit reply from MISO.
module spi_master #(
    parameter int unsigned FRAME_W  = 10,
    parameter int unsigned RD_W     = 8,
    parameter int unsigned RD_TURN  = 2,
    parameter int unsigned IDLE_GAP = 1
) (
    input logic          clk,
    input logic          rst_n,
    spi_master_if.master bus
);
    localparam int unsigned MaxA   = (FRAME_W > RD_W) ? FRAME_W : RD_W;
    localparam int unsigned MaxB   = (RD_TURN > IDLE_GAP) ? RD_TURN : IDLE_GAP;
    localparam int unsigned MaxLen = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = $clog2(MaxLen + 1);

    localparam logic [CntW-1:0] OutLast  = CntW'(FRAME_W - 1);
    localparam logic [CntW-1:0] TurnLast = CntW'(RD_TURN - 1);
    localparam logic [CntW-1:0] InLast   = CntW'(RD_W - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        StIdle, StSelect, StCmd, StShiftOut, StTurn, StShiftIn, StGap
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic               rd_q, rd_d;
    logic [RD_W-2:0]    rx_sh_q, rx_sh_d;
    logic [RD_W-1:0]    rx_data_q, rx_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sh_q      <= '0;
            rd_q      <= 1'b0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            rd_q      <= rd_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        rd_d      = rd_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.start) begin
                    sh_d    = bus.tx_frame;
                    rd_d    = (bus.tx_frame[FRAME_W-1 -: 2] == 2'b11);
                    state_d = StSelect;
                end
            end
            StSelect: state_d = StCmd;
            StCmd: begin
                cnt_d   = '0;
                state_d = StShiftOut;
            end
            StShiftOut: begin
                // MSB stays on MOSI through SELECT/CMD; shifting starts here
                sh_d = {sh_q[FRAME_W-2:0], 1'b0};
                if (cnt_q == OutLast) begin
                    cnt_d   = '0;
                    state_d = rd_q ? StTurn : StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTurn: begin
                if (cnt_q == TurnLast) begin
                    cnt_d   = '0;
                    state_d = StShiftIn;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShiftIn: begin
                rx_sh_d = {rx_sh_q[RD_W-3:0], bus.MISO};
                if (cnt_q == InLast) begin
                    rx_data_d = {rx_sh_q, bus.MISO};
                    cnt_d     = '0;
                    state_d   = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from state so an async reset forces SS_n high at once
    logic done_w;
    assign done_w       = (state_q == StGap) && (cnt_q == '0);
    assign bus.done     = done_w;
    assign bus.rx_valid = done_w && rd_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.SS_n     = (state_q == StIdle) || (state_q == StGap);
    assign bus.MOSI     = ((state_q == StSelect) || (state_q == StCmd) ||
                           (state_q == StShiftOut)) ? sh_q[FRAME_W-1] : 1'b0;
    assign bus.rx_data  = rx_data_q;
endmodule
